// File: rtl/btc_host_ctrl.sv
// Mining host sequencer: loads barrier mask, midstate and work into a core over its
// packet port, then sweeps nonces until the core's barrier reports a hit or the space runs out.

package btc_host_pkg;
    localparam int mask_length_gp = 3;

    typedef enum logic [1:0] {
        NET_NULL = 2'd0,
        NET_REG  = 2'd1,
        NET_PC   = 2'd2,
        NET_BAR  = 2'd3
    } net_op_e;

    typedef struct packed {
        logic [3:0]  reserved;
        logic [9:0]  ID;
        net_op_e     net_op;
        logic [9:0]  net_addr;
        logic [31:0] net_data;
    } net_packet_s;
endpackage

module btc_host_ctrl
    import btc_host_pkg::*;
#(
    parameter logic [9:0]  net_ID_p        = 10'd1,
    parameter logic [31:0] bar_mask_p      = 32'd7,
    parameter logic [9:0]  bar_addr_p      = 10'd24,
    parameter logic [9:0]  midstate_base_p = 10'd1,
    parameter logic [9:0]  work_base_p     = 10'd9,
    parameter logic [9:0]  nonce_reg_p     = 10'd1,
    parameter logic [9:0]  cmd_reg_p       = 10'd20,
    parameter logic [31:0] pc_start_p      = 32'h2,
    parameter int          settle_p        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [255:0]              midstate_i,
    input  logic [95:0]               work_i,
    input  logic [31:0]               nonce_start_i,
    input  logic [mask_length_gp-1:0] barrier_i,
    output net_packet_s               net_packet_o,
    output logic                      busy_o,
    output logic                      found_o,
    output logic                      exhausted_o,
    output logic [31:0]               found_nonce_o,
    output logic [31:0]               nonce_cur_o
);

    localparam int SW = $clog2(settle_p + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BAR, S_MID, S_WORK, S_CMD, S_PC, S_ARM, S_WAIT, S_NONCE, S_HALT
    } state_e;

    // Encoding doubles as the command word written to the core.
    typedef enum logic [1:0] {
        PH_LDWORK  = 2'd1,
        PH_LDNONCE = 2'd2,
        PH_DONE    = 2'd3
    } phase_e;

    state_e        state_reg, state_next;
    phase_e        phase_reg, phase_next;
    logic [2:0]    idx_reg, idx_next;
    logic [SW-1:0] settle_reg, settle_next;
    logic [255:0]  mid_reg, mid_next;
    logic [95:0]   work_reg, work_next;
    logic [31:0]   nstart_reg, nstart_next;
    logic [31:0]   ncur_reg, ncur_next;
    logic [31:0]   fnonce_reg, fnonce_next;
    logic          busy_reg, busy_next;
    logic          found_reg, found_next;
    logic          exh_reg, exh_next;
    net_packet_s   pkt_reg, pkt_next;

    logic [31:0] mid_word [8];
    logic [31:0] work_word [3];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mid
            assign mid_word[gi] = mid_reg[255-32*gi -: 32];
        end
        for (gi = 0; gi < 3; gi++) begin : g_work
            assign work_word[gi] = work_reg[95-32*gi -: 32];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            phase_reg  <= PH_LDWORK;
            idx_reg    <= '0;
            settle_reg <= '0;
            mid_reg    <= '0;
            work_reg   <= '0;
            nstart_reg <= '0;
            ncur_reg   <= '0;
            fnonce_reg <= '0;
            busy_reg   <= 1'b0;
            found_reg  <= 1'b0;
            exh_reg    <= 1'b0;
            pkt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            idx_reg    <= idx_next;
            settle_reg <= settle_next;
            mid_reg    <= mid_next;
            work_reg   <= work_next;
            nstart_reg <= nstart_next;
            ncur_reg   <= ncur_next;
            fnonce_reg <= fnonce_next;
            busy_reg   <= busy_next;
            found_reg  <= found_next;
            exh_reg    <= exh_next;
            pkt_reg    <= pkt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        idx_next    = idx_reg;
        settle_next = settle_reg;
        mid_next    = mid_reg;
        work_next   = work_reg;
        nstart_next = nstart_reg;
        ncur_next   = ncur_reg;
        fnonce_next = fnonce_reg;
        busy_next   = busy_reg;
        found_next  = found_reg;
        exh_next    = exh_reg;
        pkt_next          = '0;
        pkt_next.ID       = net_ID_p;
        pkt_next.net_op   = NET_NULL;

        case (state_reg)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    mid_next    = midstate_i;
                    work_next   = work_i;
                    nstart_next = nonce_start_i;
                    busy_next   = 1'b1;
                    found_next  = 1'b0;
                    exh_next    = 1'b0;
                    phase_next  = PH_LDWORK;
                    state_next  = S_BAR;
                end
            end
            S_BAR: begin
                pkt_next.net_op   = NET_BAR;
                pkt_next.net_addr = bar_addr_p;
                pkt_next.net_data = bar_mask_p;
                idx_next          = '0;
                state_next        = S_MID;
            end
            S_MID: begin
                pkt_next.net_op   = NET_REG;
                pkt_next.net_addr = midstate_base_p + {7'd0, idx_reg};
                pkt_next.net_data = mid_word[idx_reg];
                if (idx_reg == 3'd7) begin
                    idx_next   = '0;
                    state_next = S_WORK;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            S_WORK: begin
                pkt_next.net_op   = NET_REG;
                pkt_next.net_addr = work_base_p + {8'd0, idx_reg[1:0]};
                pkt_next.net_data = work_word[idx_reg[1:0]];
                if (idx_reg == 3'd2) begin
                    idx_next   = '0;
                    state_next = S_CMD;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            S_CMD: begin
                pkt_next.net_op   = NET_REG;
                pkt_next.net_addr = cmd_reg_p;
                pkt_next.net_data = {30'd0, phase_reg};
                state_next        = S_PC;
            end
            S_PC: begin
                pkt_next.net_op   = NET_PC;
                pkt_next.net_data = pc_start_p;
                state_next        = S_ARM;
            end
            S_ARM: begin
                pkt_next.net_addr = bar_addr_p;
                pkt_next.net_data = 32'hFFFF_FFFE;
                settle_next       = SW'(settle_p);
                if (phase_reg == PH_DONE) begin
                    busy_next  = 1'b0;
                    state_next = S_HALT;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Barrier is unreliable right after the PC restart; let it settle first.
                if (settle_reg != '0) begin
                    settle_next = settle_reg - SW'(1);
                end else if (barrier_i == '0) begin
                    if (phase_reg == PH_LDWORK) begin
                        ncur_next  = nstart_reg;
                        phase_next = PH_LDNONCE;
                        state_next = S_NONCE;
                    end else if (ncur_reg == 32'hFFFF_FFFF) begin
                        exh_next   = 1'b1;
                        phase_next = PH_DONE;
                        state_next = S_CMD;
                    end else begin
                        ncur_next  = ncur_reg + 32'd1;
                        state_next = S_NONCE;
                    end
                end else if (barrier_i == mask_length_gp'(1)) begin
                    found_next  = 1'b1;
                    fnonce_next = ncur_reg;
                    phase_next  = PH_DONE;
                    state_next  = S_CMD;
                end
            end
            S_NONCE: begin
                pkt_next.net_op   = NET_REG;
                pkt_next.net_addr = nonce_reg_p;
                pkt_next.net_data = ncur_reg;
                state_next        = S_CMD;
            end
            default: state_next = S_IDLE;
        endcase

        if (abort_i) begin
            state_next       = S_IDLE;
            busy_next        = 1'b0;
            found_next       = 1'b0;
            exh_next         = 1'b0;
            pkt_next         = '0;
            pkt_next.ID      = net_ID_p;
            pkt_next.net_op  = NET_NULL;
        end
    end

    assign net_packet_o  = pkt_reg;
    assign busy_o        = busy_reg;
    assign found_o       = found_reg;
    assign exhausted_o   = exh_reg;
    assign found_nonce_o = fnonce_reg;
    assign nonce_cur_o   = ncur_reg;

endmodule

// File: tb/tb_btc_host_ctrl.sv
// Randomized bench for btc_host_ctrl: a cycle-accurate transaction script predicts every
// packet and flag from the host's sequencing rules; one process compares on each falling edge.

module tb_btc_host_ctrl;
    import btc_host_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      start_i = 1'b0;
    logic                      abort_i = 1'b0;
    logic [255:0]              midstate_i = '0;
    logic [95:0]               work_i = '0;
    logic [31:0]               nonce_start_i = '0;
    logic [mask_length_gp-1:0] barrier_i = '0;
    net_packet_s               net_packet_o;
    logic                      busy_o, found_o, exhausted_o;
    logic [31:0]               found_nonce_o, nonce_cur_o;

    btc_host_ctrl dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .midstate_i(midstate_i), .work_i(work_i), .nonce_start_i(nonce_start_i),
        .barrier_i(barrier_i), .net_packet_o(net_packet_o), .busy_o(busy_o),
        .found_o(found_o), .exhausted_o(exhausted_o), .found_nonce_o(found_nonce_o),
        .nonce_cur_o(nonce_cur_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // model state (value after the next edge) and the snapshot being compared
    logic        m_busy = 0, m_found = 0, m_exh = 0;
    logic [31:0] m_fnonce = 0, m_ncur = 0;
    net_packet_s exp_pkt = '0;
    logic        exp_busy = 0, exp_found = 0, exp_exh = 0;
    logic [31:0] exp_fnonce = 0, exp_ncur = 0;

    localparam logic [255:0] TV_MID =
        256'h56f6950a_86a3a529_7961969c_7bfdb28c_54c9af5a_951237b8_7979d96f_c01823e1;
    localparam logic [95:0] TV_WORK = 96'ha24c2683_cf1beb52_2cf50119;

    function automatic net_packet_s mk(input net_op_e op, input logic [9:0] a, input logic [31:0] d);
        net_packet_s p;
        p = '0;
        p.ID = 10'd1;
        p.net_op = op;
        p.net_addr = a;
        p.net_data = d;
        return p;
    endfunction

    net_packet_s NULLP;
    initial NULLP = mk(NET_NULL, 10'd0, 32'd0);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin
        wait (cmp_en);
        forever begin
            @(negedge clk);
            check("pkt", 64'(net_packet_o), 64'(exp_pkt));
            check("busy", 64'(busy_o), 64'(exp_busy));
            check("found", 64'(found_o), 64'(exp_found));
            check("exhausted", 64'(exhausted_o), 64'(exp_exh));
            check("found_nonce", 64'(found_nonce_o), 64'(exp_fnonce));
            check("nonce_cur", 64'(nonce_cur_o), 64'(exp_ncur));
        end
    end

    task automatic step(input net_packet_s p);
        @(posedge clk);
        exp_pkt = p;
        exp_busy = m_busy;
        exp_found = m_found;
        exp_exh = m_exh;
        exp_fnonce = m_fnonce;
        exp_ncur = m_ncur;
        #1;
    endtask

    // Inputs that must not matter while busy: stray starts, barrier, unlatched data.
    task automatic noise();
        start_i = ($urandom_range(0, 5) == 0);
        barrier_i = mask_length_gp'($urandom_range(0, 7));
        for (int w = 0; w < 8; w++) midstate_i[32*w +: 32] = $urandom;
        work_i = {$urandom, $urandom, $urandom};
        nonce_start_i = $urandom;
    endtask

    task automatic tail(input int ph);
        noise(); step(mk(NET_REG, 10'd20, 32'(ph)));
        noise(); step(mk(NET_PC, 10'd0, 32'd2));
        noise();
        if (ph == 3) m_busy = 0;
        step(mk(NET_NULL, 10'd24, 32'hFFFF_FFFE));
    endtask

    task automatic load_burst(input logic [255:0] mid, input logic [95:0] wk, input logic [31:0] ns);
        start_i = 1'b1; midstate_i = mid; work_i = wk; nonce_start_i = ns;
        m_busy = 1; m_found = 0; m_exh = 0;
        step(NULLP);
        noise(); step(mk(NET_BAR, 10'd24, 32'd7));
        for (int k = 0; k < 8; k++) begin
            noise(); step(mk(NET_REG, 10'(1 + k), mid[255-32*k -: 32]));
        end
        for (int k = 0; k < 3; k++) begin
            noise(); step(mk(NET_REG, 10'(9 + k), wk[95-32*k -: 32]));
        end
        tail(1);
    endtask

    task automatic settle_wait(input int g);
        for (int i = 0; i < 4; i++) begin noise(); step(NULLP); end
        for (int j = 0; j < g; j++) begin
            noise(); barrier_i = mask_length_gp'($urandom_range(2, 7)); step(NULLP);
        end
        noise();
    endtask

    task automatic run_job(input logic [255:0] mid, input logic [95:0] wk, input logic [31:0] ns,
                           input bit hit_en, input logic [31:0] hit_n, input int gmax);
        int ph;
        bit done;
        int iters;
        load_burst(mid, wk, ns);
        ph = 1; done = 0; iters = 0;
        while (!done) begin
            iters++;
            if (iters > 64) begin
                check("job_iter_bound", 64'(iters), 64'd64);
                break;
            end
            settle_wait($urandom_range(0, gmax));
            if (ph == 1) begin
                barrier_i = '0; m_ncur = ns; ph = 2; step(NULLP);
                noise(); step(mk(NET_REG, 10'd1, m_ncur)); tail(2);
            end else if (hit_en && m_ncur == hit_n) begin
                barrier_i = mask_length_gp'(1); m_found = 1; m_fnonce = m_ncur; step(NULLP);
                tail(3); done = 1;
            end else if (m_ncur == 32'hFFFF_FFFF) begin
                barrier_i = '0; m_exh = 1; step(NULLP);
                tail(3); done = 1;
            end else begin
                barrier_i = '0; m_ncur = m_ncur + 32'd1; step(NULLP);
                noise(); step(mk(NET_REG, 10'd1, m_ncur)); tail(2);
            end
        end
        start_i = 1'b0;
        step(NULLP); step(NULLP);
    endtask

    initial begin
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        step('0); step('0);
        reset = 1'b1;
        step(NULLP); step(NULLP);

        // reset in the middle of the midstate words
        start_i = 1'b1; midstate_i = TV_MID; work_i = TV_WORK; nonce_start_i = 0;
        m_busy = 1; step(NULLP);
        start_i = 1'b0;
        step(mk(NET_BAR, 10'd24, 32'd7));
        step(mk(NET_REG, 10'd1, 32'h56f6950a));
        check("mid0_literal", 64'(net_packet_o.net_data), 64'h56f6950a);
        step(mk(NET_REG, 10'd2, 32'h86a3a529));
        reset = 1'b0;
        #1 check("reset_async_null", 64'(net_packet_o), 64'd0);
        m_busy = 0; m_found = 0; m_exh = 0; m_fnonce = 0; m_ncur = 0;
        exp_pkt = '0; exp_busy = 0; exp_found = 0; exp_exh = 0; exp_fnonce = 0; exp_ncur = 0;
        step('0); step('0);
        reset = 1'b1;
        step(NULLP);

        // fresh start after reset, then abort mid-burst
        start_i = 1'b1; m_busy = 1; step(NULLP);
        start_i = 1'b0; step(mk(NET_BAR, 10'd24, 32'd7));
        check("bar_data_literal", 64'(net_packet_o.net_data), 64'd7);
        check("bar_addr_literal", 64'(net_packet_o.net_addr), 64'd24);
        step(mk(NET_REG, 10'd1, 32'h56f6950a));
        abort_i = 1'b1; m_busy = 0; step(NULLP);
        abort_i = 1'b0; step(NULLP);

        // reference vector, hit at nonce 5
        run_job(TV_MID, TV_WORK, 32'd0, 1'b1, 32'd5, 2);
        check("found_nonce_literal", 64'(found_nonce_o), 64'd5);
        check("found_literal", 64'(found_o), 64'd1);
        check("busy_halt_literal", 64'(busy_o), 64'd0);

        // abort in HALT clears the sticky flags
        abort_i = 1'b1; m_found = 0; m_exh = 0; step(NULLP);
        abort_i = 1'b0; step(NULLP);
        check("found_after_abort", 64'(found_o), 64'd0);

        // nonce space end, no wrap
        run_job(TV_MID, TV_WORK, 32'hFFFF_FFFE, 1'b0, 32'd0, 1);
        check("exhausted_literal", 64'(exhausted_o), 64'd1);
        check("nonce_last_literal", 64'(nonce_cur_o), 64'hFFFF_FFFF);

        // non-0/1 barrier held in WAIT: no packets, stray starts ignored, then abort
        load_burst({8{$urandom}}, {3{$urandom}}, $urandom);
        settle_wait(0);
        for (int i = 0; i < 20; i++) begin
            noise(); barrier_i = 3'b010; step(NULLP);
        end
        abort_i = 1'b1; m_busy = 0; step(NULLP);
        abort_i = 1'b0; start_i = 1'b0; step(NULLP);

        // randomized jobs
        for (int j = 0; j < 6; j++) begin
            logic [255:0] rm;
            logic [95:0]  rw;
            logic [31:0]  rn;
            for (int w = 0; w < 8; w++) rm[32*w +: 32] = $urandom;
            rw = {$urandom, $urandom, $urandom};
            if (j % 2 == 0) begin
                rn = $urandom;
                run_job(rm, rw, rn, 1'b1, rn + 32'($urandom_range(0, 3)), 3);
            end else begin
                rn = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
                run_job(rm, rw, rn, 1'b0, 32'd0, 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btc_host_ctrl.md
Name: btc_host_ctrl

Overview:
Hardware mining host that drives a core_flattened instance over its network packet input. It replaces bench-side sequencing with RTL:
- loads the barrier mask, midstate and work words into the core;
- issues the LDWORK / LDNONCE / DONE commands and restarts the core PC;
- watches the core's barrier output and advances the nonce until a hit or until the nonce space is exhausted.

It sits directly upstream of the core: net_packet_o feeds the core's net_packet_flat_i, and barrier_i comes from the core's barrier_o.

Parameters:
- net_ID_p, 10'd1, ID field stamped on every packet.
- bar_mask_p, 32'd7, barrier mask data sent in the BAR packet.
- bar_addr_p, 10'd24, net_addr used for BAR and ARM packets.
- midstate_base_p, 10'd1, core register for midstate word 0 (words go to base..base+7).
- work_base_p, 10'd9, core register for work word 0 (words go to base..base+2).
- nonce_reg_p, 10'd1, core register that receives the nonce.
- cmd_reg_p, 10'd20, core command register.
- pc_start_p, 32'h2, net_data of the PC packet.
- settle_p, 4, cycles after ARM during which barrier_i is ignored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; accepted only in IDLE or HALT.
- abort_i  in  1  forces IDLE on the next edge.
- midstate_i  in  256  latched at start; word k = [255-32k -: 32].
- work_i  in  96  latched at start; word k = [95-32k -: 32].
- nonce_start_i  in  32  first nonce tried; latched at start.
- barrier_i  in  mask_length_gp  barrier_o of the core.
- net_packet_o  out  $bits(net_packet_s)  registered packet to the core.
- busy_o  out  1  high from start acceptance until HALT or IDLE.
- found_o  out  1  sticky hit flag.
- exhausted_o  out  1  sticky flag: nonce space done without a hit.
- found_nonce_o  out  32  nonce that produced the hit.
- nonce_cur_o  out  32  nonce currently loaded in the core.

Behaviour:
- Reset (async, reset==0):
  - state IDLE;
  - net_packet_o all fields zero with net_op=NULL;
  - busy_o, found_o, exhausted_o = 0;
  - found_nonce_o, nonce_cur_o = 0;
  - phase = LDWORK; index counter = 0; settle counter = 0.
- Packet format and timing:
  - Every packet carries ID=net_ID_p and reserved=0.
  - net_packet_o is a register: exactly one packet per cycle, appearing the cycle after the state that produces it.
  - In IDLE, WAIT and HALT the output is NULL, data 0, addr 0.
- IDLE: start_i=1 → latch inputs; busy_o=1; phase=LDWORK → BAR.
- BAR: emit BAR, data bar_mask_p, addr bar_addr_p → MID with idx=0.
- MID: emit REG, addr midstate_base_p+idx, data midstate word idx. idx 7 → WORK with idx=0.
- WORK: emit REG, addr work_base_p+idx, data work word idx. idx 2 → CMD.
- CMD: emit REG, addr cmd_reg_p, data = 1 / 2 / 3 for phase LDWORK / LDNONCE / DONE → PC.
- PC: emit PC, data pc_start_p, addr 0 → ARM.
- ARM: emit NULL, data 32'hFFFFFFFE, addr bar_addr_p. Load settle counter = settle_p.
  - Phase DONE → HALT.
  - Otherwise → WAIT.
- WAIT: decrement the settle counter while it is nonzero; barrier_i is ignored until it reads 0. Then:
  - barrier_i==0 and phase LDWORK → nonce_cur = nonce_start; phase = LDNONCE → NONCE.
  - barrier_i==0 and phase LDNONCE:
    - if nonce_cur==32'hFFFFFFFF → exhausted_o=1; phase = DONE → CMD;
    - else nonce_cur+1 (32-bit) → NONCE.
  - barrier_i==1 → found_o=1; found_nonce_o = nonce_cur; phase = DONE → CMD.
  - Any other value → stay in WAIT.
- NONCE: emit REG, addr nonce_reg_p, data nonce_cur → CMD.
- HALT: busy_o=0; flags held. start_i restarts as from IDLE and clears found_o and exhausted_o.
- start_i while busy: ignored.
- abort_i: highest priority except reset. Next edge gives:
  - state IDLE; NULL output;
  - busy_o=0, found_o=0, exhausted_o=0.
- Asynchronous reset mid-sequence:
  - net_packet_o goes NULL immediately;
  - no partial packet is ever held.
- Latency:
  - 15 packets from start to WAIT (BAR, 8 MID, 3 WORK, CMD, PC, ARM).
  - 4 packets per nonce iteration (NONCE, CMD, PC, ARM).

Test Plan:
- Reset asserted mid-MID → output NULL in the same cycle. After release, all outputs are 0 and state is IDLE. A fresh start_i yields BAR with data 7, addr 24.
- start_i with midstate 56f6950a_86a3a529_7961969c_7bfdb28c_54c9af5a_951237b8_7979d96f_c01823e1 and work a24c2683_cf1beb52_2cf50119 → cycles 1..15 show:
  - BAR;
  - REG addr 1..8 with the words in order, e.g. addr 1 = 56f6950a;
  - REG addr 9..11 = a24c2683, cf1beb52, 2cf50119;
  - REG addr 20 data 1;
  - PC data 2;
  - NULL data FFFFFFFE addr 24.
- Barrier model returns 0 with nonce_start 0 → REG addr 1 data 0, then REG addr 20 data 2, PC, ARM. On the next 0: nonce_cur_o=1 and REG addr 1 data 1.
- Model returns 1 when nonce==5 → found_o=1, found_nonce_o=5. Then REG addr 20 data 3, PC, ARM, HALT; busy_o=0.
- nonce_start 32'hFFFFFFFE with barrier always 0 → tries FFFFFFFE and FFFFFFFF, then exhausted_o=1 and cmd 3. No wrap to 0.
- barrier_i=3'b010 held in WAIT → no packets issued. abort_i → IDLE with flags cleared; start_i during busy is ignored.
